alu_seq: RTL
============

# alu_seq

Multi-cycle, parametrised successor of the lab combinational ALU. It accepts operands through a start/done handshake and computes single-cycle ops in one clock. MUL, DIV and MOD use iterative shift-add and restoring-division datapaths that take WIDTH clocks. It presents a registered 2·WIDTH result and registered NZCV flags, and sits between the operand/opcode input registers and the seven-segment decoder stage.

## Interface
- WIDTH, 4, operand width in bits (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A (unsigned for MUL/DIV/MOD/shifts, two's complement for V).
- b  in  WIDTH  operand B / shift amount.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR; 10–15 illegal.
- result  out  2·WIDTH  registered result; upper WIDTH bits zero except for MUL.
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered flags.
- busy  out  1  high while an accepted operation is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, FIN. Reset → IDLE; result=0, all flags=0, busy=0, done=0.
- IDLE + start: latch a, b, op; busy=1.
  - MUL/DIV/MOD → RUN with iteration counter=0.
  - All others → FIN.
- RUN: one iteration per clock. After WIDTH iterations → FIN.
  - MUL: shift-add on a 2·WIDTH accumulator.
  - DIV/MOD: restoring division, one quotient bit per clock, MSB first.
- FIN: write result and flags, pulse done=1, clear busy → IDLE.
- start while busy=1 is ignored. Operands and op are not re-sampled mid-operation.
- Arithmetic rules:
  - ADD: result[WIDTH-1:0]=a+b. C=carry out. V=(a,b same sign) & (sum sign differs).
  - SUB: a−b mod 2^WIDTH. C=borrow (1 when a<b unsigned). V=(a,b signs differ) & (result sign ≠ a sign).
  - MUL: full 2·WIDTH product. C=V=(product[2W-1:W]≠0).
  - DIV: quotient. MOD: remainder.
  - b=0: DIV gives quotient all-ones (WIDTH bits), MOD gives remainder=a; V=1 in both cases.
  - AND/OR/XOR: bitwise. SHL/SHR: logical shift by b; b≥WIDTH gives 0.
  - Illegal op: result=0, flags Z=1 only.
- Flags:
  - N = result[2W-1] for MUL, result[WIDTH-1] otherwise.
  - Z = (result==0) over the full 2·WIDTH.
  - C, V = 0 for ops not listed above.
- Result and flags hold their last values until the next FIN.

## Timing
- Start accepted at edge k. busy=1 from k+1 until done.
- Single-cycle ops: done=1 and result valid in cycle k+1 (latency 1). busy is high for that cycle only and drops at k+2.
- MUL/DIV/MOD: done and result in cycle k+WIDTH+1. busy high cycles k+1..k+WIDTH+1.
- done is never high two consecutive cycles. A new start is accepted in the cycle busy=0 following done (back-to-back throughput: one op per 2 cycles minimum).
- rst asserted in any state, including mid-RUN: at the next edge go to IDLE, zero all outputs, no done for the aborted op. rst has priority over start.

## Test plan
- WIDTH=4, ADD a=7 b=9 → cycle k+1: done=1, result=0x00, Z=1, C=1, V=0, N=0. Then ADD 7+1 → 0x08, N=1, V=1.
- SUB a=3 b=5 → result=0x0E, N=1, C=1, V=0. SHL a=1 b=5 → result=0, Z=1. SHR a=8 b=3 → 0x01.
- MUL a=15 b=15 → busy high k+1..k+5; done exactly at k+5; result=0xE1, N=1, C=V=1. Start pulsed at k+2 is ignored.
- DIV a=13 b=4 → 0x03; MOD 13,4 → 0x01. DIV 9,0 → 0x0F with V=1. MOD 9,0 → 0x09 with V=1. All complete at k+5.
- Start MUL 6×7, assert rst at k+2 → busy=0, result=0, flags=0 at k+3, no done. Then MUL 6×7 → 0x2A at done.
- Illegal op 12 → done at k+1, result=0, Z=1, N=C=V=0. Back-to-back ADDs issued whenever busy=0 each produce exactly one done pulse.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU with a start/done handshake, registered 2*WIDTH result and NZCV flags.
// MUL uses shift-add, DIV/MOD use restoring division, each taking WIDTH iterations.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         op,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_n,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_v,
    output logic               busy,
    output logic               done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] WIDTH_VAL = (WIDTH + 1)'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                           OP_MOD = 4'd4, OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7,
                           OP_SHL = 4'd8, OP_SHR = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [3:0]         op_reg;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic               is_multi, last_iter;

    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    logic [3:0]         src_op;
    logic [WIDTH-1:0]   src_a, src_b, shl_val, shr_val;
    logic [WIDTH:0]     sum, diff;
    logic               shift_ok;
    logic [2*WIDTH-1:0] res;
    logic               res_n, res_z, res_c, res_v;

    assign is_multi  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    assign last_iter = (cnt == LAST_CNT);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    // acc holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV and MOD
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        div_diff  = div_shift[WIDTH-1:0] - b_reg;
        if (op_reg == OP_MUL)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else
            acc_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    // Single-cycle ops resolve from the live inputs in IDLE; iterative ops from latched state
    always_comb begin
        src_op   = (state == IDLE) ? op : op_reg;
        src_a    = (state == IDLE) ? a  : a_reg;
        src_b    = (state == IDLE) ? b  : b_reg;
        sum      = {1'b0, src_a} + {1'b0, src_b};
        diff     = {1'b0, src_a} - {1'b0, src_b};
        shift_ok = ({1'b0, src_b} < WIDTH_VAL);
        shl_val  = src_a << src_b;
        shr_val  = src_a >> src_b;
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        case (src_op)
            OP_ADD: begin
                res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                res_c = sum[WIDTH];
                res_v = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                res_c = diff[WIDTH];
                res_v = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_MUL: begin
                res   = acc_next;
                res_c = |acc_next[2*WIDTH-1:WIDTH];
                res_v = |acc_next[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                res   = {{WIDTH{1'b0}}, acc_next[WIDTH-1:0]};
                res_v = (src_b == '0);
            end
            OP_MOD: begin
                res   = {{WIDTH{1'b0}}, acc_next[2*WIDTH-1:WIDTH]};
                res_v = (src_b == '0);
            end
            OP_AND: res = {{WIDTH{1'b0}}, src_a & src_b};
            OP_OR:  res = {{WIDTH{1'b0}}, src_a | src_b};
            OP_XOR: res = {{WIDTH{1'b0}}, src_a ^ src_b};
            OP_SHL: res = {{WIDTH{1'b0}}, (shift_ok ? shl_val : '0)};
            OP_SHR: res = {{WIDTH{1'b0}}, (shift_ok ? shr_val : '0)};
            default: res = '0;
        endcase
        res_n = (src_op == OP_MUL) ? res[2*WIDTH-1] : res[WIDTH-1];
        res_z = (res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = is_multi ? RUN : FIN;
            RUN:     if (last_iter) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result and flags are written on the edge that enters FIN so they are valid with done
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg  <= a;
                    b_reg  <= b;
                    op_reg <= op;
                    cnt    <= '0;
                    if (is_multi) begin
                        acc <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                    end else begin
                        result <= res;
                        flag_n <= res_n;
                        flag_z <= res_z;
                        flag_c <= res_c;
                        flag_v <= res_v;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        result <= res;
                        flag_n <= res_n;
                        flag_z <= res_z;
                        flag_c <= res_c;
                        flag_v <= res_v;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
